// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 active-low matrix keypad scanner with debounce and a
// 32-bit hex entry register.
//
// The keypad columns are driven one at a time and the rows are read back.
// A full scan covers all four columns. A press is accepted once the same
// single key has been seen for DEBOUNCE_SCANS full scans in a row. A release
// is accepted once the keypad has read empty for DEBOUNCE_SCANS full scans.
// Each accepted key pulses key_valid for one cycle and is shifted into
// entry_value as the newest (lowest) nibble.
//
// Optional feature: define KEY_REPEAT_EN to make a held key auto-repeat.
// The repeat fires every REPEAT_SCANS full scans. Without the macro the
// repeat counter is not built and each press is accepted exactly once.
//
// Ports:
//   clk_g        in   system clock
//   rst_n        in   synchronous reset, active-low
//   key_row[3:0] in   keypad rows, active-low, asynchronous to clk_g
//   key_col[3:0] out  column drive; exactly one bit is low
//   clear        in   zeroes entry_value and entry_digits on the next edge
//   key_valid    out  one-cycle pulse for each accepted key
//   key_code[3:0] out code of the last accepted key, {row[1:0], col[1:0]}
//   entry_value[31:0] out  shifted hex entry; newest digit in [3:0]
//   entry_digits[3:0] out  number of digits entered, saturates at 8

module keypad_entry #(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic        clk_g,
  input  logic        rst_n,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] entry_value,
  output logic [3:0]  entry_digits
);

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB      = 4'(DEBOUNCE_SCANS);

  // Reject illegal parameter values at elaboration time.
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_cfg
    $error("keypad_entry: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD} state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_e;

  // ---------------------------------------------------------------------
  // Synchroniser, column scan and per-column hit capture
  // ---------------------------------------------------------------------
  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [2:0][3:0]  hits_q;      // pressed rows of columns 0..2, active-high
  logic             sample, scan_done;

  assign sample    = (div_q == DIV_LAST);
  assign scan_done = sample && (col_q == 2'd3);

  always_ff @(posedge clk_g) begin
    if (!rst_n) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      div_q      <= '0;
      col_q      <= 2'd0;
      // NOTE: the hit registers are reset with everything else; they are
      // rewritten every scan, but a reset keeps the first result clean.
      hits_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // pre-edge values and the two-flop synchroniser really has two stages.
      row_meta_q <= key_row;
      row_sync_q <= row_meta_q;
      if (sample) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        unique case (col_q)
          2'd0:    hits_q[0] <= ~row_sync_q;
          2'd1:    hits_q[1] <= ~row_sync_q;
          2'd2:    hits_q[2] <= ~row_sync_q;
          default: ;  // column 3 is evaluated directly from row_sync_q
        endcase
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign key_col = ~(4'b0001 << col_q);

  // ---------------------------------------------------------------------
  // Scan result: the bit index of the pressed matrix is the key code
  // {row, col}. Column 3 is taken live on the column-3 sample edge.
  // ---------------------------------------------------------------------
  logic [3:0][3:0] col_hits;
  logic [15:0]     pressed;
  logic [4:0]      n_hits;
  logic [3:0]      key_idx;
  result_e         result;

  assign col_hits = {~row_sync_q, hits_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    pressed = '0;
    key_idx = 4'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        pressed[r*4 + c] = col_hits[c][r];
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) key_idx = 4'(i);
    end
    n_hits = 5'($countones(pressed));
    if (n_hits == 5'd0)      result = RES_NONE;
    else if (n_hits == 5'd1) result = RES_SINGLE;
    else                     result = RES_MULTI;
  end

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] stable_q, stable_d;
  logic [3:0] rel_q, rel_d;
  logic       accept_q, accept_d;   // accept pending, applied on the next edge
  logic       match;

  assign match = (result == RES_SINGLE) && (key_idx == cand_q);

`ifdef KEY_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk_g) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= 4'd0;
      stable_q <= 4'd0;
      rel_q    <= 4'd0;
      accept_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
      accept_q <= accept_d;
`ifdef KEY_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (scan_done) begin
      unique case (state_q)
        S_IDLE:
          if (result == RES_SINGLE) state_d = (DEB == 4'd1) ? S_HELD : S_CONFIRM;
        S_CONFIRM:
          if (!match)                           state_d = S_IDLE;
          else if (stable_q + 4'd1 == DEB)      state_d = S_HELD;
        S_HELD:
          if (result == RES_NONE && rel_q + 4'd1 == DEB) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    accept_d = 1'b0;
    cand_d   = cand_q;
    stable_d = stable_q;
    rel_d    = rel_q;
`ifdef KEY_REPEAT_EN
    rep_d    = rep_q;
`endif
    if (scan_done) begin
      unique case (state_q)
        S_IDLE: begin
          if (result == RES_SINGLE) begin
            cand_d   = key_idx;
            stable_d = 4'd1;
            rel_d    = 4'd0;
            accept_d = (DEB == 4'd1);
`ifdef KEY_REPEAT_EN
            rep_d    = '0;
`endif
          end
        end
        S_CONFIRM: begin
          if (match) begin
            stable_d = stable_q + 4'd1;
            accept_d = (stable_q + 4'd1 == DEB);
          end else begin
            stable_d = 4'd0;
          end
        end
        S_HELD: begin
          if (result == RES_NONE) begin
            rel_d = rel_q + 4'd1;
`ifdef KEY_REPEAT_EN
            rep_d = '0;
`endif
          end else begin
            // Anything on the keypad, including a different key, restarts
            // the release count; a different key is never accepted here.
            rel_d = 4'd0;
`ifdef KEY_REPEAT_EN
            if (match) begin
              if (rep_q + 1'b1 == REP_LAST) begin
                accept_d = 1'b1;
                rep_d    = '0;
              end else begin
                rep_d    = rep_q + 1'b1;
              end
            end else begin
              rep_d = '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Key event and entry register. cand_q cannot change between the
  // accepting scan-result edge and the following edge, so it is the code.
  // ---------------------------------------------------------------------
  logic        key_valid_q;
  logic [3:0]  key_code_q;
  logic [31:0] entry_q;
  logic [3:0]  digits_q;

  always_ff @(posedge clk_g) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      entry_q     <= '0;
      digits_q    <= 4'd0;
    end else begin
      key_valid_q <= accept_q;
      if (accept_q) key_code_q <= cand_q;
      if (clear) begin
        entry_q  <= '0;
        digits_q <= 4'd0;
      end else if (accept_q) begin
        entry_q  <= {entry_q[27:0], cand_q};
        if (digits_q != 4'd8) digits_q <= digits_q + 4'd1;
      end
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign entry_value  = entry_q;
  assign entry_digits = digits_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry. A keypad model pulls rows low for held keys
// in the driven column. Stimulus changes only at scan boundaries. A
// scan-level reference model predicts each accept and the entry register.
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int REP      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic        clk_g = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] entry_value;
  logic [3:0]  entry_digits;
  logic [15:0] keys = '0;    // bit r*4+c set = key at row r, column c held

  always #5 clk_g = ~clk_g;

  keypad_entry #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk_g       (clk_g),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_value (entry_value),
    .entry_digits(entry_digits)
  );

  // Passive matrix: a held key shorts its row to its column.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !key_col[c]) key_row[r] = 1'b0;
  end

  int pulses_seen = 0;
  always @(negedge clk_g) if (key_valid === 1'b1) pulses_seen++;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (one call per full scan) -------------
  logic [31:0] m_entry;
  int          m_digits;
  logic [3:0]  m_code, m_cand;
  bit          m_held, m_pending;
  int          m_streak, m_rel, m_rep, m_pulses;

  task automatic model_reset();
    m_entry = '0; m_digits = 0; m_code = 4'd0; m_cand = 4'd0;
    m_held = 0; m_pending = 0; m_streak = 0; m_rel = 0; m_rep = 0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int n;
    int idx;
    n   = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    m_pending = 0;
    if (!m_held) begin
      if (m_streak == 0) begin
        if (n == 1) begin m_cand = 4'(idx); m_streak = 1; end
      end else if (n == 1 && 4'(idx) == m_cand) begin
        m_streak++;
      end else begin
        m_streak = 0;
      end
      if (m_streak == DEB) begin
        m_pending = 1; m_held = 1; m_rel = 0; m_rep = 0;
      end
    end else if (n == 0) begin
      m_rel++;
      m_rep = 0;
      if (m_rel == DEB) begin m_held = 0; m_streak = 0; end
    end else begin
      m_rel = 0;
`ifdef KEY_REPEAT_EN
      if (n == 1 && 4'(idx) == m_cand) begin
        m_rep++;
        if (m_rep == REP) begin m_pending = 1; m_rep = 0; end
      end else begin
        m_rep = 0;
      end
`endif
    end
  endtask

  // One full scan with keys k. clr is asserted for the first edge of the
  // scan, which is also the edge that applies an accept from the last scan.
  task automatic do_scan(input logic [15:0] k, input bit clr, input string tag);
    bit exp_kv;
    keys  = k;
    clear = clr;
    @(posedge clk_g); #1;
    clear  = 1'b0;
    exp_kv = m_pending;
    if (m_pending) begin
      m_code   = m_cand;
      m_entry  = (m_entry << 4) | {28'd0, m_cand};
      m_digits = (m_digits < 8) ? m_digits + 1 : 8;
      m_pulses++;
      m_pending = 0;
    end
    if (clr) begin m_entry = '0; m_digits = 0; end
    check({tag, "_valid"},  {31'd0, key_valid}, {31'd0, exp_kv});
    check({tag, "_code"},   {28'd0, key_code}, {28'd0, m_code});
    check({tag, "_entry"},  entry_value, m_entry);
    check({tag, "_digits"}, {28'd0, entry_digits}, 32'(m_digits));
    repeat (SCAN_CYC - 1) @(posedge clk_g);
    #1;
    check({tag, "_pulses"}, 32'(pulses_seen), 32'(m_pulses));
    model_scan(k);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_g);
    #1;
    model_reset();
    check({tag, "_col"},    {28'd0, key_col}, 32'h0000_000E);
    check({tag, "_valid"},  {31'd0, key_valid}, 32'd0);
    check({tag, "_code"},   {28'd0, key_code}, 32'd0);
    check({tag, "_entry"},  entry_value, 32'd0);
    check({tag, "_digits"}, {28'd0, entry_digits}, 32'd0);
    check({tag, "_pulses"}, 32'(pulses_seen), 32'(m_pulses));
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] key_bit(input int code);
    return 16'(1) << code;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a;
    int b;
    int len;
    int gap;
    int kind;
    logic [15:0] k;

    m_pulses = 0;
    model_reset();

    // 1. Reset values, then one column-walk scan with no keys.
    apply_reset("rst");
    for (int n = 1; n <= SCAN_CYC; n++) begin
      @(posedge clk_g); #1;
      check($sformatf("colwalk%0d", n), {28'd0, key_col},
            {28'd0, 4'b1111 ^ (4'b0001 << ((n / SCAN_DIV) % 4))});
    end
    model_scan(16'd0);

    // 2. Row 1 / column 2 held for 5 scans, then released.
    repeat (5) do_scan(key_bit(6), 0, "press6");
    repeat (3) do_scan(16'd0, 0, "rel6");
    check("t2_entry",  entry_value, 32'h0000_0006);
    check("t2_digits", {28'd0, entry_digits}, 32'd1);

    // 3. Codes 1..8 fill the entry, 9 pushes out the oldest digit.
    do_scan(16'd0, 1, "clr3");
    for (int c = 1; c <= 9; c++) begin
      repeat (3) do_scan(key_bit(c), 0, $sformatf("fill%0d", c));
      repeat (3) do_scan(16'd0, 0, $sformatf("gap%0d", c));
      if (c == 8) check("t3_entry8", entry_value, 32'h1234_5678);
    end
    check("t3_entry9",  entry_value, 32'h2345_6789);
    check("t3_digits9", {28'd0, entry_digits}, 32'd8);

    // 4. Bounce: present, absent, present -> never two scans in a row.
    base = pulses_seen;
    do_scan(key_bit(4), 0, "bnc_a");
    do_scan(16'd0,      0, "bnc_b");
    do_scan(key_bit(4), 0, "bnc_c");
    repeat (3) do_scan(16'd0, 0, "bnc_d");
    check("t4_no_pulse", 32'(pulses_seen - base), 32'd0);
    check("t4_entry",    entry_value, 32'h2345_6789);

    // Candidate replaced by a different key during confirmation.
    do_scan(key_bit(1), 0, "swap_a");
    repeat (3) do_scan(key_bit(2), 0, "swap_b");
    repeat (3) do_scan(16'd0, 0, "swap_c");

    // A different key while held is not accepted.
    repeat (3) do_scan(key_bit(7), 0, "held7");
    repeat (3) do_scan(key_bit(8), 0, "held8");
    repeat (3) do_scan(16'd0, 0, "held_rel");

    // 5. Two keys together, then clear coinciding with the accept of key 3.
    base = pulses_seen;
    repeat (4) do_scan(key_bit(0) | key_bit(5), 0, "multi");
    check("t5_multi_no_pulse", 32'(pulses_seen - base), 32'd0);
    repeat (2) do_scan(16'd0, 0, "multi_rel");
    repeat (2) do_scan(key_bit(3), 0, "k3");
    do_scan(key_bit(3), 1, "k3_clr");
    check("t5_code",   {28'd0, key_code}, 32'd3);
    check("t5_entry",  entry_value, 32'd0);
    check("t5_digits", {28'd0, entry_digits}, 32'd0);
    repeat (3) do_scan(16'd0, 0, "k3_rel");

    // 6. Key A held for 10 scans.
    base = pulses_seen;
    repeat (10) do_scan(key_bit(10), 0, "holdA");
    repeat (3) do_scan(16'd0, 0, "holdA_rel");
`ifndef KEY_REPEAT_EN
    check("t6_one_pulse", 32'(pulses_seen - base), 32'd1);
    check("t6_entry", entry_value, 32'h0000_000A);
`endif

    // Reset in the middle of a scan while a key is being confirmed.
    keys = key_bit(12);
    do_scan(key_bit(12), 0, "mid_a");
    repeat (7) @(posedge clk_g);
    #1;
    apply_reset("rst_mid");
    repeat (3) do_scan(16'd0, 0, "after_mid");

    // Reset landing exactly on the accept edge: the event is dropped.
    repeat (2) do_scan(key_bit(9), 0, "acc_rst");
    apply_reset("rst_acc");
    repeat (3) do_scan(16'd0, 0, "after_acc");

    // Randomised bursts of single keys, multi-key chords, gaps and clears.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 15);
      b    = (a + 1 + $urandom_range(0, 14)) % 16;
      if (kind < 7)      k = key_bit(a);
      else if (kind < 9) k = key_bit(a) | key_bit(b);
      else               k = 16'd0;
      len = $urandom_range(1, 5);
      gap = $urandom_range(0, 3);
      for (int s = 0; s < len; s++)
        do_scan(k, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d_on", t));
      for (int s = 0; s < gap; s++)
        do_scan(16'd0, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d_off", t));
    end
    repeat (3) do_scan(16'd0, 0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
